vedic_mult_pipe: RTL and testbench



---
 rtl/vedic_mult_pipe.sv | 140 ++++++++++++++
 tb/tb_vedic_mult_pipe.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vedic_mult_pipe.sv
// Pipelined Vedic (Urdhva-Tiryakbhyam) multiplier with a valid/ready handshake.
// Signed operands are reduced to magnitudes in the first stage. The magnitudes are
// split into 2x2 base products, and each later stage merges one recursion level of
// the product tree. The last stage applies the sign and drives the output registers.
// All stages advance together. When the output is held, the whole pipe stalls.
module vedic_mult_pipe #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned TAG_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_signed,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_product,
  output logic [TAG_W-1:0]   out_tag
);

  // Lvls recursion levels: level 1 holds the 2x2 base products, and level Lvls holds the full product
  localparam int Lvls = $clog2(WIDTH);
  localparam int Nb   = WIDTH / 2;        // 2-bit chunks per operand
  localparam int Np   = Nb * Nb;          // partial-product slots per stage
  localparam int Pw   = 2 * WIDTH;        // every slot is held at full product width

  logic               w_advance;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic               w_neg;
  logic [Pw-1:0]      w_next [Lvls][Np];

  logic [Pw-1:0]      r_prod [Lvls][Np];
  logic               r_vld  [Lvls];
  logic               r_neg  [Lvls];
  logic [TAG_W-1:0]   r_tag  [Lvls];
  logic               r_out_valid;
  logic [Pw-1:0]      r_out_product;
  logic [TAG_W-1:0]   r_out_tag;

  assign w_advance   = ~r_out_valid | out_ready;
  assign in_ready    = w_advance & ~reset;
  assign out_valid   = r_out_valid;
  assign out_product = r_out_product;
  assign out_tag     = r_out_tag;

  // Operand magnitudes and result sign; -2^(WIDTH-1) maps onto itself as an unsigned value
  always_comb begin
    w_mag_a = in_a;
    w_mag_b = in_b;
    w_neg   = 1'b0;
    if (in_signed) begin
      if (in_a[WIDTH-1]) w_mag_a = -in_a;
      if (in_b[WIDTH-1]) w_mag_b = -in_b;
      w_neg = in_a[WIDTH-1] ^ in_b[WIDTH-1];
    end
  end

  // Next contents of every stage: base 2x2 products, then one combine level per stage.
  // Slot i*N+j of a level holds a_chunk[i] * b_chunk[j], where N is the number of chunks.
  always_comb begin
    logic [3:0] ca;
    logic [3:0] cb;
    logic [Pw-1:0] ll;
    logic [Pw-1:0] lh;
    logic [Pw-1:0] hl;
    logic [Pw-1:0] hh;
    ca = '0;
    cb = '0;
    ll = '0;
    lh = '0;
    hl = '0;
    hh = '0;
    for (int s = 0; s < Lvls; s++) begin
      for (int p = 0; p < Np; p++) begin
        w_next[s][p] = '0;
      end
    end
    for (int i = 0; i < Nb; i++) begin
      for (int j = 0; j < Nb; j++) begin
        ca = {2'b00, w_mag_a[2*i +: 2]};
        cb = {2'b00, w_mag_b[2*j +: 2]};
        w_next[0][i*Nb + j] = Pw'(ca * cb);
      end
    end
    // Level k merges four level k-1 products, whose half-width is 2^(k-1)
    for (int k = 2; k <= Lvls; k++) begin
      for (int i = 0; i < (WIDTH >> k); i++) begin
        for (int j = 0; j < (WIDTH >> k); j++) begin
          ll = r_prod[k-2][(2*i)   * (WIDTH >> (k-1)) + 2*j];
          lh = r_prod[k-2][(2*i)   * (WIDTH >> (k-1)) + 2*j + 1];
          hl = r_prod[k-2][(2*i+1) * (WIDTH >> (k-1)) + 2*j];
          hh = r_prod[k-2][(2*i+1) * (WIDTH >> (k-1)) + 2*j + 1];
          w_next[k-1][i * (WIDTH >> k) + j] = ll + ((hl + lh) << (1 << (k-1))) + (hh << (1 << k));
        end
      end
    end
  end

  // Control path and output registers: cleared asynchronously, so in-flight work is dropped
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < Lvls; s++) begin
        r_vld[s] <= 1'b0;
      end
      r_out_valid   <= 1'b0;
      r_out_product <= '0;
      r_out_tag     <= '0;
    end else if (w_advance) begin
      r_vld[0] <= in_valid;
      for (int s = 1; s < Lvls; s++) begin
        r_vld[s] <= r_vld[s-1];
      end
      r_out_valid   <= r_vld[Lvls-1];
      r_out_product <= r_neg[Lvls-1] ? -r_prod[Lvls-1][0] : r_prod[Lvls-1][0];
      r_out_tag     <= r_tag[Lvls-1];
    end
  end

  // Datapath registers: these need no reset because they are qualified by the valid bits
  always_ff @(posedge clk) begin
    if (w_advance) begin
      r_neg[0] <= w_neg;
      r_tag[0] <= in_tag;
      for (int s = 1; s < Lvls; s++) begin
        r_neg[s] <= r_neg[s-1];
        r_tag[s] <= r_tag[s-1];
      end
      for (int s = 0; s < Lvls; s++) begin
        for (int p = 0; p < Np; p++) begin
          r_prod[s][p] <= w_next[s][p];
        end
      end
    end
  end

endmodule

// File: tb/tb_vedic_mult_pipe.sv
// Scoreboard bench for vedic_mult_pipe. The main WIDTH=8 instance gets directed corners,
// back-to-back traffic, stalls, random backpressure and a reset mid-flight.
// Three more instances sweep WIDTH=2, 4 and 16 at full rate.
module tb_vedic_mult_pipe;

  localparam int W   = 8;
  localparam int TW  = 4;
  localparam int LAT = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  logic [W-1:0]    in_a;
  logic [W-1:0]    in_b;
  logic            in_signed;
  logic [TW-1:0]   in_tag;
  logic            out_valid;
  logic            out_ready;
  logic [2*W-1:0]  out_product;
  logic [TW-1:0]   out_tag;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int rdy_mode = 0;   // 0: out_ready high, 1: low, 2: random

  typedef struct {
    logic [2*W-1:0] prod;
    logic [TW-1:0]  tag;
    int             acc;
    bit             lat;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  vedic_mult_pipe #(.WIDTH(W), .TAG_W(TW)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a),
    .in_b(in_b), .in_signed(in_signed), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .out_product(out_product), .out_tag(out_tag)
  );

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic s);
    longint ia;
    longint ib;
    longint p;
    ia = s ? longint'($signed(a)) : longint'(a);
    ib = s ? longint'($signed(b)) : longint'(b);
    p  = ia * ib;
    return p[2*W-1:0];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // The out_ready driver: the pattern is selected by rdy_mode and updated on each falling edge
  always begin
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'b0;
      default: out_ready = ($urandom_range(0, 3) != 0);
    endcase
    @(negedge clk);
  end

  // The monitor: this process pops the scoreboard for each output transfer that happens on the next rising edge
  always begin
    exp_t e;
    @(negedge clk);
    #1;
    if (!reset && out_valid && out_ready) begin
      if (q.size() == 0) begin
        fail_now("spurious_out_valid");
      end else begin
        e = q.pop_front();
        check("product", out_product, e.prod);
        check("tag", out_tag, e.tag);
        if (e.lat) check("latency", cyc + 1 - e.acc, LAT);
      end
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                      input logic [TW-1:0] t, input logic [2*W-1:0] expp, input bit lat);
    int n;
    n = 0;
    @(negedge clk);
    in_valid  = 1'b1;
    in_a      = a;
    in_b      = b;
    in_signed = s;
    in_tag    = t;
    #1;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) fail_now("accept_timeout");
    else q.push_back('{expp, t, cyc + 1, lat});
  endtask

  task automatic send_rand(input bit lat);
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         s;
    logic [TW-1:0] t;
    a = W'($urandom);
    b = W'($urandom);
    s = 1'($urandom);
    t = TW'($urandom);
    send(a, b, s, t, ref_mul(a, b, s), lat);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) fail_now("drain_timeout");
  endtask

  // The main stimulus sequence
  initial begin
    int n;
    reset = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_signed = 1'b0; in_tag = '0;
    #12;
    check("reset_out_valid", out_valid, 0);
    check("reset_out_product", out_product, 0);
    check("reset_out_tag", out_tag, 0);
    check("reset_in_ready", in_ready, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("in_ready_after_reset", in_ready, 1);

    // Directed cases with spec constants
    send(8'd255, 8'd255, 1'b0, 4'd3, 16'hFE01, 1'b1);
    idle();
    wait_drain();
    send(8'h80, 8'h80, 1'b1, 4'd1, 16'h4000, 1'b1);
    send(8'hFF, 8'h7F, 1'b1, 4'd2, 16'hFF81, 1'b1);
    send(8'h80, 8'h00, 1'b1, 4'd4, 16'h0000, 1'b1);
    send(8'h80, 8'h01, 1'b1, 4'd5, 16'hFF80, 1'b1);
    send(8'h80, 8'h80, 1'b0, 4'd6, 16'h4000, 1'b1);
    send(8'hFF, 8'hFF, 1'b1, 4'd7, 16'h0001, 1'b1);
    idle();
    wait_drain();

    // Back-to-back random traffic, 16 transactions with mixed signedness
    for (int i = 0; i < 16; i++) send_rand(1'b1);
    idle();
    wait_drain();

    // Fill the pipe, then stall the output for 5 cycles
    for (int i = 0; i < LAT; i++) send_rand(1'b0);
    rdy_mode = 1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("stall_in_ready", in_ready, 0);
      check("stall_out_valid", out_valid, 1);
      if (q.size() != 0) begin
        check("stall_product", out_product, q[0].prod);
        check("stall_tag", out_tag, q[0].tag);
      end
      if (i == 4) rdy_mode = 0;
      @(negedge clk);
    end
    wait_drain();

    // Random traffic with random gaps and random backpressure
    rdy_mode = 2;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 3) == 0) idle();
      send_rand(1'b0);
    end
    idle();
    rdy_mode = 0;
    wait_drain();

    // Assert reset between clock edges with work still in flight
    for (int i = 0; i < LAT; i++) send_rand(1'b0);
    rdy_mode = 1;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("pre_reset_out_valid", out_valid, 1);
    #1;
    reset = 1'b1;
    #1;
    check("midreset_out_valid", out_valid, 0);
    check("midreset_out_product", out_product, 0);
    check("midreset_out_tag", out_tag, 0);
    check("midreset_in_ready", in_ready, 0);
    q.delete();
    rdy_mode = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    send(8'd12, 8'd13, 1'b0, 4'd9, 16'd156, 1'b1);
    idle();
    wait_drain();

    // Wait for the width sweeps to finish
    n = 0;
    while (!(g_sweep[0].done && g_sweep[1].done && g_sweep[2].done) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (!(g_sweep[0].done && g_sweep[1].done && g_sweep[2].done)) fail_now("sweep_timeout");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Width sweep instances: exhaustive for widths 2 and 4, random for width 16, at full rate
  logic sw_rst;
  initial begin
    sw_rst = 1'b1;
    #22;
    sw_rst = 1'b0;
  end

  for (genvar g = 0; g < 3; g++) begin : g_sweep
    localparam int SW   = (g == 0) ? 2 : (g == 1) ? 4 : 16;
    localparam int SLAT = $clog2(SW) + 1;
    localparam int NTX  = (SW <= 4) ? (2 << (2 * SW)) : 10000;

    logic            v;
    logic            rdy;
    logic            s;
    logic            ov;
    logic [SW-1:0]   a;
    logic [SW-1:0]   b;
    logic [2*SW-1:0] p;
    logic [TW-1:0]   t;
    logic [TW-1:0]   ot;
    logic [2*SW-1:0] qp[$];
    logic [TW-1:0]   qt[$];
    int              qc[$];
    bit              done = 1'b0;

    vedic_mult_pipe #(.WIDTH(SW), .TAG_W(TW)) u_dut (
      .clk(clk), .reset(sw_rst), .in_valid(v), .in_ready(rdy), .in_a(a), .in_b(b),
      .in_signed(s), .in_tag(t), .out_valid(ov), .out_ready(1'b1), .out_product(p),
      .out_tag(ot)
    );

    function automatic logic [2*SW-1:0] sref(input logic [SW-1:0] x, input logic [SW-1:0] y,
                                             input logic sg);
      longint ix;
      longint iy;
      longint r;
      ix = sg ? longint'($signed(x)) : longint'(x);
      iy = sg ? longint'($signed(y)) : longint'(y);
      r  = ix * iy;
      return r[2*SW-1:0];
    endfunction

    // This process drives the sweep stimulus
    initial begin
      logic [31:0] nv;
      int          w;
      v = 1'b0; a = '0; b = '0; s = 1'b0; t = '0;
      repeat (3) @(negedge clk);
      for (int n = 0; n < NTX; n++) begin
        @(negedge clk);
        v = 1'b1;
        nv = 32'(n);
        if (SW <= 4) begin
          a = SW'(nv >> SW);
          b = SW'(nv);
          s = ((nv >> (2 * SW)) & 32'd1) != 0;
        end else begin
          a = SW'($urandom);
          b = SW'($urandom);
          s = 1'($urandom);
        end
        t = TW'(n);
        #1;
        if (!rdy) begin
          fail_now($sformatf("w%0d_in_ready", SW));
        end else begin
          qp.push_back(sref(a, b, s));
          qt.push_back(t);
          qc.push_back(cyc + 1);
        end
      end
      @(negedge clk);
      v = 1'b0;
      w = 0;
      while (qp.size() != 0 && w < 200) begin
        @(negedge clk);
        w++;
      end
      if (qp.size() != 0) fail_now($sformatf("w%0d_drain_timeout", SW));
      done = 1'b1;
    end

    // This process is the sweep monitor
    always begin
      @(negedge clk);
      #1;
      if (!sw_rst && ov) begin
        if (qp.size() == 0) begin
          fail_now($sformatf("w%0d_spurious_out_valid", SW));
        end else begin
          check($sformatf("w%0d_product", SW), p, qp.pop_front());
          check($sformatf("w%0d_tag", SW), ot, qt.pop_front());
          check($sformatf("w%0d_latency", SW), cyc + 1 - qc.pop_front(), SLAT);
        end
      end
    end
  end

endmodule
